// File: rtl/board_render_fsm_if.sv
// Board-memory and VGA plot signals between the render sequencer and its
// BRAM / VGA adapter.
interface board_render_fsm_if #(
    parameter int ADDR_W   = 9,
    parameter int COLOUR_W = 3
);
    logic [ADDR_W-1:0]   wr_addr;
    logic [COLOUR_W-1:0] wr_data;
    logic                wr_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [COLOUR_W-1:0] rd_data;
    logic [9:0]          x;
    logic [8:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;

    modport master (
        output wr_addr, wr_data, wr_en, rd_addr,
        input  rd_data,
        output x, y, colour, plot
    );

    modport slave (
        input  wr_addr, wr_data, wr_en, rd_addr,
        output rd_data,
        input  x, y, colour, plot
    );
endinterface

// File: rtl/board_render_fsm.sv
// Latches N player tiles, erases/writes them into board memory, then rasterises
// the board to the VGA plot port for NUM_FRAMES paced frames.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; positions latched on start
// S_ERASE | one cycle per player: previous tile <= BG_COLOUR
// S_WRITE | one cycle per player: new tile <= player or collide colour
// S_FETCH | present tile address t to the registered board memory
// S_PLOT  | TILE_PX^2 pixels of tile t, colour taken from rd_data
// S_WAIT  | FRAME_DIV idle cycles between frames
module board_render_fsm #(
    parameter int                  GRID_W      = 16,
    parameter int                  GRID_H      = 16,
    parameter int                  TILE_PX     = 10,
    parameter int                  NUM_PLAYERS = 2,
    parameter int                  COLOUR_W    = 3,
    parameter int                  ADDR_W      = 9,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = '0,
    parameter int                  FRAME_DIV   = 416666,
    parameter int                  NUM_FRAMES  = 5
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [4*NUM_PLAYERS-1:0]        player_x,
    input  logic [4*NUM_PLAYERS-1:0]        player_y,
    input  logic [COLOUR_W*NUM_PLAYERS-1:0] player_colour,
    input  logic [COLOUR_W-1:0]             collide_colour,
    board_render_fsm_if.master              bus,
    output logic [3:0]                      frame_index,
    output logic                            busy,
    output logic                            done,
    output logic                            bad_pos
);
    localparam int NT   = GRID_W * GRID_H;
    localparam int T_W  = (NT > 1) ? $clog2(NT) : 1;
    localparam int P_W  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int PX_W = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
    localparam int WT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ERASE = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_PLOT  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    logic [2:0]          state;
    logic [P_W-1:0]      idx;
    logic [T_W-1:0]      t;
    logic [3:0]          tx;
    logic [9:0]          bx;
    logic [8:0]          by;
    logic [PX_W-1:0]     px, py;
    logic [WT_W-1:0]     wait_cnt;
    logic                prev_valid;
    logic [3:0]          lat_x  [NUM_PLAYERS];
    logic [3:0]          lat_y  [NUM_PLAYERS];
    logic [COLOUR_W-1:0] lat_c  [NUM_PLAYERS];
    logic [3:0]          prev_x [NUM_PLAYERS];
    logic [3:0]          prev_y [NUM_PLAYERS];
    logic [COLOUR_W-1:0] col_c;

    logic [NUM_PLAYERS-1:0] in_ok, new_ok, prev_ok;
    logic                   collide;

    function automatic logic on_board(input logic [3:0] cx, input logic [3:0] cy);
        return (int'(cx) < GRID_W) && (int'(cy) < GRID_H);
    endfunction

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [3:0] cx, input logic [3:0] cy);
        return ADDR_W'(cy) * ADDR_W'(GRID_W) + ADDR_W'(cx);
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            in_ok[k]   = on_board(player_x[4*k +: 4], player_y[4*k +: 4]);
            new_ok[k]  = on_board(lat_x[k], lat_y[k]);
            prev_ok[k] = on_board(prev_x[k], prev_y[k]);
        end
    end

    // Off-board players never claim a tile, so they cannot cause a collision.
    always_comb begin
        collide = 1'b0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (j != int'(idx) && new_ok[j] && lat_x[j] == lat_x[idx] && lat_y[j] == lat_y[idx])
                collide = 1'b1;
        end
    end

    always_comb begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        bus.plot    = 1'b0;
        bus.colour  = '0;
        bus.x       = '0;
        bus.y       = '0;
        case (state)
            S_ERASE: begin
                bus.wr_en   = prev_valid && prev_ok[idx];
                bus.wr_addr = tile_addr(prev_x[idx], prev_y[idx]);
                bus.wr_data = BG_COLOUR;
            end
            S_WRITE: begin
                bus.wr_en   = new_ok[idx];
                bus.wr_addr = tile_addr(lat_x[idx], lat_y[idx]);
                bus.wr_data = collide ? col_c : lat_c[idx];
            end
            S_FETCH: bus.rd_addr = ADDR_W'(t);
            S_PLOT: begin
                bus.rd_addr = ADDR_W'(t);
                bus.plot    = 1'b1;
                bus.colour  = bus.rd_data;
                bus.x       = bx + 10'(px);
                bus.y       = by + 9'(py);
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_WAIT) && (wait_cnt == '0) && (frame_index == 4'(NUM_FRAMES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            t           <= '0;
            tx          <= '0;
            bx          <= '0;
            by          <= '0;
            px          <= '0;
            py          <= '0;
            wait_cnt    <= '0;
            frame_index <= '0;
            bad_pos     <= 1'b0;
            prev_valid  <= 1'b0;
            col_c       <= '0;
            for (int k = 0; k < NUM_PLAYERS; k++) begin
                lat_x[k]  <= '0;
                lat_y[k]  <= '0;
                lat_c[k]  <= '0;
                prev_x[k] <= '0;
                prev_y[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    for (int k = 0; k < NUM_PLAYERS; k++) begin
                        lat_x[k] <= player_x[4*k +: 4];
                        lat_y[k] <= player_y[4*k +: 4];
                        lat_c[k] <= player_colour[COLOUR_W*k +: COLOUR_W];
                    end
                    col_c   <= collide_colour;
                    bad_pos <= ~&in_ok;
                    idx     <= '0;
                    state   <= prev_valid ? S_ERASE : S_WRITE;
                end
                S_ERASE: begin
                    if (idx == P_W'(NUM_PLAYERS - 1)) begin
                        idx   <= '0;
                        state <= S_WRITE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (idx == P_W'(NUM_PLAYERS - 1)) begin
                        for (int k = 0; k < NUM_PLAYERS; k++) begin
                            prev_x[k] <= lat_x[k];
                            prev_y[k] <= lat_y[k];
                        end
                        prev_valid <= 1'b1;
                        idx        <= '0;
                        t          <= '0;
                        tx         <= '0;
                        bx         <= '0;
                        by         <= '0;
                        state      <= S_FETCH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_FETCH: begin
                    px    <= '0;
                    py    <= '0;
                    state <= S_PLOT;
                end
                S_PLOT: begin
                    if (px == PX_W'(TILE_PX - 1)) begin
                        px <= '0;
                        if (py == PX_W'(TILE_PX - 1)) begin
                            py <= '0;
                            if (t == T_W'(NT - 1)) begin
                                wait_cnt <= WT_W'(FRAME_DIV - 1);
                                state    <= S_WAIT;
                            end else begin
                                t <= t + 1'b1;
                                // bx/by track the tile origin so no divide by GRID_W is needed
                                if (tx == 4'(GRID_W - 1)) begin
                                    tx <= '0;
                                    bx <= '0;
                                    by <= by + 9'(TILE_PX);
                                end else begin
                                    tx <= tx + 1'b1;
                                    bx <= bx + 10'(TILE_PX);
                                end
                                state <= S_FETCH;
                            end
                        end else begin
                            py <= py + 1'b1;
                        end
                    end else begin
                        px <= px + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        t  <= '0;
                        tx <= '0;
                        bx <= '0;
                        by <= '0;
                        if (frame_index == 4'(NUM_FRAMES - 1)) begin
                            frame_index <= '0;
                            state       <= S_IDLE;
                        end else begin
                            frame_index <= frame_index + 1'b1;
                            state       <= S_FETCH;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_render_fsm.sv
// Randomised bench for board_render_fsm: an event-list model predicts every
// memory write and pixel plot, plus run length, done and bad_pos.
module tb_board_render_fsm;
    localparam int GW = 4, GH = 4, TP = 2, NP = 2, CW = 3, AW = 4, FD = 8, NF = 2;
    localparam int NT = GW * GH;
    localparam int FRAME_CYC = NT * (1 + TP * TP) + FD;
    localparam logic [CW-1:0] BG = 3'b000;

    logic clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic [4*NP-1:0]  player_x = '0, player_y = '0;
    logic [CW*NP-1:0] player_colour = '0;
    logic [CW-1:0]    collide_colour = '0;
    logic [3:0]       frame_index;
    logic             busy, done, bad_pos;

    board_render_fsm_if #(.ADDR_W(AW), .COLOUR_W(CW)) bus ();

    board_render_fsm #(
        .GRID_W(GW), .GRID_H(GH), .TILE_PX(TP), .NUM_PLAYERS(NP), .COLOUR_W(CW),
        .ADDR_W(AW), .BG_COLOUR(BG), .FRAME_DIV(FD), .NUM_FRAMES(NF)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .player_x(player_x), .player_y(player_y), .player_colour(player_colour),
        .collide_colour(collide_colour), .bus(bus),
        .frame_index(frame_index), .busy(busy), .done(done), .bad_pos(bad_pos)
    );

    always #5 clock = ~clock;

    logic [CW-1:0] ram [NT] = '{default: '0};
    always @(posedge clock) begin
        if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
        bus.rd_data <= ram[bus.rd_addr];
    end

    typedef struct { int a; int d; } wr_t;
    typedef struct { int x; int y; int c; int t; int f; } pl_t;

    wr_t exp_wr[$], wr_log[$];
    pl_t exp_pl[$], pl_log[$];
    int  m_x[NP], m_y[NP], m_c[NP], m_cc;
    int  m_px[NP], m_py[NP];
    bit  m_pv = 1'b0;
    int  mram[NT];
    int  exp_len = 0;
    bit  exp_bad = 1'b0;
    int  n_cmp = 0, n_bad = 0;
    int  done_cnt = 0, busy_cnt = 0, prev_rd = 0;
    bit  busy_q = 1'b0, done_q = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit on_b(input int x, input int y);
        return (x < GW) && (y < GH);
    endfunction

    // Predicts the complete transaction list of one run from the game rules.
    task automatic model_start();
        bit had_erase;
        bit coll;
        wr_t w;
        pl_t p;
        had_erase = m_pv;
        if (m_pv)
            for (int k = 0; k < NP; k++)
                if (on_b(m_px[k], m_py[k])) begin
                    w.a = m_py[k] * GW + m_px[k];
                    w.d = BG;
                    exp_wr.push_back(w);
                    mram[w.a] = w.d;
                end
        exp_bad = 1'b0;
        for (int k = 0; k < NP; k++) begin
            if (!on_b(m_x[k], m_y[k])) exp_bad = 1'b1;
            else begin
                coll = 1'b0;
                for (int j = 0; j < NP; j++)
                    if (j != k && on_b(m_x[j], m_y[j]) && m_x[j] == m_x[k] && m_y[j] == m_y[k])
                        coll = 1'b1;
                w.a = m_y[k] * GW + m_x[k];
                w.d = coll ? m_cc : m_c[k];
                exp_wr.push_back(w);
                mram[w.a] = w.d;
            end
        end
        for (int k = 0; k < NP; k++) begin
            m_px[k] = m_x[k];
            m_py[k] = m_y[k];
        end
        m_pv = 1'b1;
        for (int f = 0; f < NF; f++)
            for (int tt = 0; tt < NT; tt++)
                for (int yy = 0; yy < TP; yy++)
                    for (int xx = 0; xx < TP; xx++) begin
                        p.x = (tt % GW) * TP + xx;
                        p.y = (tt / GW) * TP + yy;
                        p.c = mram[tt];
                        p.t = tt;
                        p.f = f;
                        exp_pl.push_back(p);
                    end
        exp_len = (had_erase ? NP : 0) + NP + NF * FRAME_CYC;
    endtask

    task automatic do_start(input int x0, input int y0, input int c0,
                            input int x1, input int y1, input int c1, input int cc);
        @(negedge clock);
        m_x[0] = x0; m_y[0] = y0; m_c[0] = c0;
        m_x[1] = x1; m_y[1] = y1; m_c[1] = c1;
        m_cc = cc;
        player_x       = {4'(x1), 4'(x0)};
        player_y       = {4'(y1), 4'(y0)};
        player_colour  = {3'(c1), 3'(c0)};
        collide_colour = 3'(cc);
        wr_log.delete();
        pl_log.delete();
        model_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("done_within_budget", done_cnt - c0, 1);
        @(negedge clock);
    endtask

    task automatic pulse_start_busy(input int delay);
        repeat (delay) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    function automatic int wa(input int i);
        return (i < wr_log.size()) ? wr_log[i].a : -1;
    endfunction
    function automatic int wd(input int i);
        return (i < wr_log.size()) ? wr_log[i].d : -1;
    endfunction
    function automatic int plx(input int i);
        return (i < pl_log.size()) ? pl_log[i].x : -1;
    endfunction
    function automatic int ply(input int i);
        return (i < pl_log.size()) ? pl_log[i].y : -1;
    endfunction
    function automatic int plc(input int i);
        return (i < pl_log.size()) ? pl_log[i].c : -1;
    endfunction

    always @(negedge clock) begin
        wr_t w;
        pl_t p;
        pl_t a;
        if (!reset) begin
            busy_q = 1'b0;
            done_q = 1'b0;
        end else begin
            if (done_q) begin
                chk("busy_after_done", busy, 0);
                chk("frame_after_done", frame_index, 0);
            end
            if (bus.wr_en) begin
                chk("wr_plot_exclusive", bus.plot, 0);
                chk("write_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", bus.wr_addr, w.a);
                    chk("wr_data", bus.wr_data, w.d);
                end
                w.a = int'(bus.wr_addr);
                w.d = int'(bus.wr_data);
                wr_log.push_back(w);
            end
            if (bus.plot) begin
                chk("plot_expected", exp_pl.size() > 0, 1);
                if (exp_pl.size() > 0) begin
                    p = exp_pl.pop_front();
                    chk("plot_x", bus.x, p.x);
                    chk("plot_y", bus.y, p.y);
                    chk("plot_colour", bus.colour, p.c);
                    chk("plot_rd_addr", bus.rd_addr, p.t);
                    chk("plot_frame", frame_index, p.f);
                    if (p.x % TP == 0 && p.y % TP == 0)
                        chk("fetch_rd_addr", prev_rd, p.t);
                end
                a.x = int'(bus.x);
                a.y = int'(bus.y);
                a.c = int'(bus.colour);
                a.t = int'(bus.rd_addr);
                a.f = int'(frame_index);
                pl_log.push_back(a);
            end
            if (busy) busy_cnt = busy_q ? busy_cnt + 1 : 1;
            if (done) begin
                chk("done_single_pulse", done_q, 0);
                chk("run_length", busy_cnt, exp_len);
                chk("writes_left", exp_wr.size(), 0);
                chk("plots_left", exp_pl.size(), 0);
                chk("bad_pos_at_done", bad_pos, exp_bad);
                done_cnt++;
            end
            busy_q  = busy;
            done_q  = done;
            prev_rd = int'(bus.rd_addr);
        end
    end

    initial begin
        int runs;
        int rx0, ry0, rx1, ry1;
        int n;
        for (int i = 0; i < NT; i++) mram[i] = 0;
        runs = 0;

        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bad_pos", bad_pos, 0);
        chk("rst_frame", frame_index, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_plot", bus.plot, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        reset = 1'b1;

        // first run: no erase, two plain writes
        do_start(1, 0, 4, 2, 3, 1, 7); wait_done(); runs++;
        chk("t1_nwrites", wr_log.size(), 2);
        chk("t1_w0_addr", wa(0), 1);  chk("t1_w0_data", wd(0), 4);
        chk("t1_w1_addr", wa(1), 14); chk("t1_w1_data", wd(1), 1);
        chk("t1_nplots", pl_log.size(), 128);
        chk("t1_tile1_colour", plc(4), 4);
        chk("t1_tile14_colour", plc(56), 1);
        chk("t4_p0_x", plx(20), 2); chk("t4_p0_y", ply(20), 2);
        chk("t4_p1_x", plx(21), 3); chk("t4_p1_y", ply(21), 2);
        chk("t4_p2_x", plx(22), 2); chk("t4_p2_y", ply(22), 3);
        chk("t4_p3_x", plx(23), 3); chk("t4_p3_y", ply(23), 3);

        // collision on tile 15
        do_start(3, 3, 2, 3, 3, 5, 7); wait_done(); runs++;
        chk("t2_nwrites", wr_log.size(), 4);
        chk("t2_erase0", wa(0), 1);  chk("t2_erase0_d", wd(0), 0);
        chk("t2_erase1", wa(1), 14); chk("t2_erase1_d", wd(1), 0);
        chk("t2_w0_addr", wa(2), 15); chk("t2_w0_data", wd(2), 7);
        chk("t2_w1_addr", wa(3), 15); chk("t2_w1_data", wd(3), 7);
        chk("t2_tile15_first", plc(60), 7);
        chk("t2_tile15_last", plc(63), 7);
        chk("t2_tile15_x", plx(63), 7);
        chk("t2_tile1_bg", plc(4), 0);

        // move P0 to (0,0)
        do_start(0, 0, 2, 2, 3, 1, 6); wait_done(); runs++;
        chk("t3_w2_addr", wa(2), 0); chk("t3_w2_data", wd(2), 2);
        chk("t3_tile15_bg", plc(60), 0);
        chk("t3_tile0_colour", plc(0), 2);

        // P1 off-board
        do_start(1, 1, 3, 4, 0, 5, 6); wait_done(); runs++;
        chk("t5_nwrites", wr_log.size(), 3);
        chk("t5_w_addr", wa(2), 5); chk("t5_w_data", wd(2), 3);
        repeat (5) @(negedge clock);
        chk("t5_bad_sticky", bad_pos, 1);
        do_start(0, 1, 2, 3, 0, 4, 1);
        chk("t5_bad_cleared", bad_pos, 0);
        wait_done(); runs++;

        for (int r = 0; r < 6; r++) begin
            rx0 = $urandom_range(0, 4); ry0 = $urandom_range(0, 4);
            rx1 = $urandom_range(0, 4); ry1 = $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) begin rx1 = rx0; ry1 = ry0; end
            do_start(rx0, ry0, $urandom_range(0, 7), rx1, ry1, $urandom_range(0, 7), $urandom_range(0, 7));
            if (r % 2 == 0) pulse_start_busy($urandom_range(1, 100));
            wait_done(); runs++;
        end

        // abort during frame-0 PLOT
        do_start(1, 2, 5, 2, 1, 6, 3);
        pulse_start_busy(2);
        n = 0;
        while (pl_log.size() < 10 && n < 500) begin @(negedge clock); n++; end
        chk("abort_reached_plot", pl_log.size() >= 10, 1);
        @(negedge clock);
        reset = 1'b0;
        exp_wr.delete();
        exp_pl.delete();
        m_pv = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_plot", bus.plot, 0);
        chk("abort_wr_en", bus.wr_en, 0);
        chk("abort_frame", frame_index, 0);
        chk("abort_x", bus.x, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        do_start(2, 2, 6, 0, 3, 3, 1);
        pulse_start_busy(20);
        wait_done(); runs++;
        chk("t6_no_erase_nwrites", wr_log.size(), 2);
        chk("t6_w0_addr", wa(0), 10); chk("t6_w0_data", wd(0), 6);
        chk("t6_w1_addr", wa(1), 12); chk("t6_w1_data", wd(1), 3);
        chk("done_count", done_cnt, runs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/board_render_fsm.md
Name: board_render_fsm

Overview:
Parametrised successor to the two-player game-board sequencer. It latches N player tile positions, erases their previous tiles, and writes new tiles into board memory, resolving collisions. It then rasterises the whole board to the VGA plot interface, tile by tile, for a configurable number of paced animation frames. It sits between the player logic and the board BRAM / VGA adapter.

Parameters:
GRID_W, 16, board width in tiles (power of two not required)
GRID_H, 16, board height in tiles
TILE_PX, 10, tile edge length in pixels
NUM_PLAYERS, 2, number of player channels (1..8)
COLOUR_W, 3, colour width
ADDR_W, 9, board memory address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H
BG_COLOUR, 3'b000, colour written when erasing a tile
FRAME_DIV, 416666, idle cycles between frames (50 MHz / 120)
NUM_FRAMES, 5, frames rendered per start

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-low
start  in  1  level; sampled only in IDLE
player_x  in  4*NUM_PLAYERS  tile X per player; player k occupies bits [4k+3:4k]
player_y  in  4*NUM_PLAYERS  tile Y per player
player_colour  in  COLOUR_W*NUM_PLAYERS  tile colour per player
collide_colour  in  COLOUR_W  colour for a tile shared by two or more players
wr_addr  out  ADDR_W  board memory write address
wr_data  out  COLOUR_W  board memory write data
wr_en  out  1  board memory write strobe
rd_addr  out  ADDR_W  board memory read address (registered memory, 1-cycle latency)
rd_data  in  COLOUR_W  board memory read data
x  out  10  VGA pixel X
y  out  9  VGA pixel Y
colour  out  COLOUR_W  VGA pixel colour
plot  out  1  VGA write strobe
frame_index  out  4  current frame, 0-based
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last frame's wait completes
bad_pos  out  1  sticky; set when any latched position is off-board; cleared on the next start

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; prev_valid cleared; latched positions cleared.
- Tile address = y*GRID_W + x. A position with x>=GRID_W or y>=GRID_H produces no write and sets bad_pos.
- IDLE: when start=1, latch all player_x/y/colour and collide_colour, then go to ERASE. A start asserted while busy is ignored.
- ERASE: NUM_PLAYERS cycles. In cycle k: wr_en=1, wr_addr=previous position of player k, wr_data=BG_COLOUR. The whole state is skipped (0 cycles, straight to WRITE) when prev_valid=0.
- WRITE: NUM_PLAYERS cycles. In cycle k: wr_en=1, wr_addr=new address of player k. wr_data=collide_colour if any other player's new address equals it, else player_colour[k]. On exit: previous positions <= new positions; prev_valid <= 1.
- FETCH: 1 cycle; rd_addr = tile counter t, starting at 0 for each frame.
- PLOT: TILE_PX*TILE_PX cycles. rd_addr is held at t; plot=1; colour=rd_data; x=(t mod GRID_W)*TILE_PX+px; y=(t div GRID_W)*TILE_PX+py. px increments fastest, 0..TILE_PX-1, then py increments. After the last pixel: if t < GRID_W*GRID_H-1, increment t and go to FETCH; otherwise go to WAIT.
- WAIT: FRAME_DIV cycles with plot=0. Then, if frame_index < NUM_FRAMES-1, increment frame_index and go to FETCH (t=0). Otherwise pulse done for 1 cycle, clear frame_index, and go to IDLE.
- Cycles per frame = GRID_W*GRID_H*(1+TILE_PX^2) + FRAME_DIV.
- wr_en and plot are never high in the same cycle. wr_en=0 outside ERASE/WRITE; plot=0 outside PLOT.
- Reset asserted mid-operation aborts immediately. No further writes or plots occur, and prev_valid=0, so the next start performs no erase.

Test Plan:
Use GRID_W=4, GRID_H=4, TILE_PX=2, NUM_PLAYERS=2, FRAME_DIV=8, NUM_FRAMES=2 with a behavioural 16x3 registered RAM.
1. First start after reset, P0=(1,0) colour 4, P1=(2,3) colour 1 -> no erase; exactly 2 writes: addr1<=4, addr14<=1. Each frame gives 64 plots in 80 cycles plus 8 wait cycles; 128 plots total; done pulses once; busy falls the next cycle.
2. Collision, P0=P1=(3,3), collide_colour=7 -> both write cycles write addr15<=7; the plots for tile 15 at x∈{6,7}, y∈{6,7} carry colour 7.
3. Second start with P0 moved to (0,0) -> ERASE writes addr1<=0 and addr14<=0 (or the previous tiles), then WRITE writes addr0; tile 1 renders as BG_COLOUR.
4. Pixel order, tile 5 -> plots in order (2,2), (3,2), (2,3), (3,3). rd_addr=5 from the FETCH cycle through the last PLOT cycle.
5. Off-board P1=(4,0) -> only P0's write occurs; bad_pos=1 until the next start.
6. Reset pulled low during PLOT of frame 0, then a new start -> outputs 0 immediately; the new run performs no ERASE; start pulses during busy are ignored.
